// File: rtl/pic_prio_sequencer_if.sv
// pic_prio_sequencer_if
//  Bundle between the PIC control/register logic and the priority sequencer.
//  master : drives requests, mask, INTA, vector base, EOI/priority commands.
//  slave  : the sequencer; returns int_o, irr_clr, isr and the bus vector.
//  Optional aeoi signal exists only when PIC_AEOI_EN is defined.
interface pic_prio_sequencer_if;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       eoi_wr;
  logic       eoi_spec;
  logic [2:0] eoi_lvl;
  logic       eoi_rot;
  logic       set_prio;
`ifdef PIC_AEOI_EN
  logic       aeoi;
`endif
  logic       int_o;
  logic [7:0] irr_clr;
  logic [7:0] isr;
  logic [7:0] data_o;
  logic       data_oe;

  modport master (
`ifdef PIC_AEOI_EN
    output aeoi,
`endif
    output irr, imr, inta_n, vec_base, eoi_wr, eoi_spec, eoi_lvl, eoi_rot, set_prio,
    input  int_o, irr_clr, isr, data_o, data_oe
  );

  modport slave (
`ifdef PIC_AEOI_EN
    input  aeoi,
`endif
    input  irr, imr, inta_n, vec_base, eoi_wr, eoi_spec, eoi_lvl, eoi_rot, set_prio,
    output int_o, irr_clr, isr, data_o, data_oe
  );
endinterface

// File: rtl/pic_prio_sequencer.sv
// pic_prio_sequencer
//  Priority resolver + INTA sequencer for an 8-level PIC. Picks the highest
//  priority unmasked request (rotating priority, lowest-priority pointer lp),
//  raises int_o, runs the two-pulse INTA handshake, owns the ISR and drives
//  the vector {vec_base, level} during the second INTA pulse.
//  Ports: clk, rst (async, active high), bus (pic_prio_sequencer_if.slave).
//  Option: PIC_AEOI_EN adds bus.aeoi; auto-EOI clears isr[win] at the end
//  of the second INTA pulse.
module pic_prio_sequencer #(
  parameter int         NLVL     = 8,
  parameter logic [2:0] SPUR_LVL = 3'd7
) (
  input  logic                clk,
  input  logic                rst,
  pic_prio_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_t;

  localparam logic [NLVL-1:0] ONE = NLVL'(1);

  // {found, level} of the highest-priority set bit; priority runs lp+1 .. lp
  function automatic logic [3:0] top_lvl(input logic [NLVL-1:0] v, input logic [2:0] lp);
    logic [3:0] r;
    logic [2:0] l;
    r = 4'd0;
    for (int i = NLVL - 1; i >= 0; i--) begin
      l = lp + 3'(i) + 3'd1;
      if (v[l]) r = {1'b1, l};
    end
    return r;
  endfunction

  // 0 = highest priority
  function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] lp);
    return l - lp - 3'd1;
  endfunction

  state_t          state;
  logic [2:0]      inta_pipe;   // [0] meta flop, [1] synced, [2] previous synced
  logic [2:0]      lp_q;
  logic [2:0]      win_q;
  logic [NLVL-1:0] isr_q;
  logic [NLVL-1:0] irr_clr_q;
  logic [7:0]      data_q;
  logic            data_oe_q;
  logic            int_q;
`ifdef PIC_AEOI_EN
  logic            spur_q;
`endif

  logic            pulse, rise;
  logic [NLVL-1:0] cand, eoi_clr, isr_eoi, isr_nxt;
  logic [3:0]      isr_top, cand_top, post_top;
  logic            eoi_hit, req_valid, enter_ack1, ack2_exit, aeoi_fire;
  logic [2:0]      eoi_at, lp_nxt;

  assign pulse = inta_pipe[2] & ~inta_pipe[1];
  assign rise  = ~inta_pipe[2] & inta_pipe[1];

  assign enter_ack1 = ((state == IDLE) || (state == REQ)) && pulse;
  assign ack2_exit  = (state == ACK2) && rise;

`ifdef PIC_AEOI_EN
  assign aeoi_fire = ack2_exit & bus.aeoi & ~spur_q;
`else
  assign aeoi_fire = 1'b0;
`endif

  always_comb begin
    cand    = bus.irr & ~bus.imr;
    isr_top = top_lvl(isr_q, lp_q);

    // EOI is applied before the request is evaluated so a same-cycle ACK1
    // sees the post-clear ISR.
    eoi_clr = '0;
    eoi_hit = 1'b0;
    eoi_at  = isr_top[2:0];
    if (bus.eoi_wr) begin
      if (bus.eoi_spec) begin
        eoi_clr[bus.eoi_lvl] = 1'b1;
        eoi_hit = 1'b1;
        eoi_at  = bus.eoi_lvl;
      end else if (isr_top[3]) begin
        eoi_clr[isr_top[2:0]] = 1'b1;
        eoi_hit = 1'b1;
      end
    end
    isr_eoi = isr_q & ~eoi_clr;

    cand_top  = top_lvl(cand, lp_q);
    post_top  = top_lvl(isr_eoi, lp_q);
    req_valid = cand_top[3] &&
                (!post_top[3] || (rank(cand_top[2:0], lp_q) < rank(post_top[2:0], lp_q)));

    isr_nxt = isr_eoi;
    if (enter_ack1 && req_valid) isr_nxt = isr_nxt | (ONE << cand_top[2:0]);
    if (aeoi_fire)               isr_nxt = isr_nxt & ~(ONE << win_q);

    // explicit EOI beats auto-EOI rotation; set_prio loses to any EOI strobe
    lp_nxt = lp_q;
    if (aeoi_fire && bus.eoi_rot) lp_nxt = win_q;
    if (bus.eoi_wr) begin
      if (bus.eoi_rot && eoi_hit) lp_nxt = eoi_at;
    end else if (bus.set_prio) begin
      lp_nxt = bus.eoi_lvl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inta_pipe <= 3'b111;
      lp_q      <= 3'd7;
      win_q     <= 3'd0;
      isr_q     <= '0;
      irr_clr_q <= '0;
      data_q    <= 8'd0;
      data_oe_q <= 1'b0;
      int_q     <= 1'b0;
`ifdef PIC_AEOI_EN
      spur_q    <= 1'b0;
`endif
    end else begin
      inta_pipe <= {inta_pipe[1:0], bus.inta_n};
      isr_q     <= isr_nxt;
      lp_q      <= lp_nxt;
      irr_clr_q <= '0;
      if (enter_ack1) begin
        // a pulse in IDLE is simply an acknowledge that may turn out spurious
        state <= ACK1;
        int_q <= 1'b0;
        win_q <= req_valid ? cand_top[2:0] : SPUR_LVL;
        if (req_valid) irr_clr_q <= ONE << cand_top[2:0];
`ifdef PIC_AEOI_EN
        spur_q <= ~req_valid;
`endif
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            state <= REQ;
            int_q <= 1'b1;
          end
          REQ: if (!req_valid) begin
            state <= IDLE;
            int_q <= 1'b0;
          end
          ACK1: if (pulse) begin
            state     <= ACK2;
            data_q    <= {bus.vec_base, win_q};
            data_oe_q <= 1'b1;
          end
          ACK2: if (rise) begin
            state     <= IDLE;
            data_q    <= 8'd0;
            data_oe_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.int_o   = int_q;
  assign bus.irr_clr = irr_clr_q;
  assign bus.isr     = isr_q;
  assign bus.data_o  = data_q;
  assign bus.data_oe = data_oe_q;

endmodule

// File: tb/tb_pic_prio_sequencer.sv
// tb_pic_prio_sequencer
//  Table of priority-resolution vectors (lp, irr, imr -> int_o, acknowledged
//  level) followed by hand-written multi-cycle sequences: nesting, rotating
//  EOI, withdrawn request, EOI colliding with ACK1, reset during ACK2, AEOI.
module tb_pic_prio_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pic_prio_sequencer_if bus();

  pic_prio_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [4:0] VB = 5'h15;

  typedef struct {
    logic [2:0] lp;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       exp_int;
    logic [2:0] exp_lvl;
  } vec_t;

  vec_t tv[10];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    bus.irr      = 8'h00;
    bus.imr      = 8'h00;
    bus.inta_n   = 1'b1;
    bus.vec_base = VB;
    bus.eoi_wr   = 1'b0;
    bus.eoi_spec = 1'b0;
    bus.eoi_lvl  = 3'd0;
    bus.eoi_rot  = 1'b0;
    bus.set_prio = 1'b0;
`ifdef PIC_AEOI_EN
    bus.aeoi     = 1'b0;
`endif
    repeat (2) tick;
    rst = 1'b0;
    tick;
  endtask

  // Full two-pulse acknowledge; acts as the IRR register by dropping the
  // bit named by irr_clr.
  task automatic do_ack(output logic [7:0] clr_or, output logic [7:0] vec, output logic oe_seen);
    clr_or = 8'h00; vec = 8'h00; oe_seen = 1'b0;
    bus.inta_n = 1'b0;
    repeat (4) begin
      tick;
      clr_or = clr_or | bus.irr_clr;
      if (bus.irr_clr != 8'h00) bus.irr = bus.irr & ~bus.irr_clr;
    end
    bus.inta_n = 1'b1;
    repeat (3) tick;
    bus.inta_n = 1'b0;
    repeat (4) begin
      tick;
      if (bus.data_oe) begin
        oe_seen = 1'b1;
        vec     = bus.data_o;
      end
    end
    bus.inta_n = 1'b1;
    repeat (4) tick;
  endtask

  logic [7:0] clr, vec;
  logic       oe;

  initial begin
    //        lp     irr    imr    int   lvl
    tv[0] = '{3'd7, 8'h24, 8'h00, 1'b1, 3'd2};
    tv[1] = '{3'd7, 8'h80, 8'h00, 1'b1, 3'd7};
    tv[2] = '{3'd7, 8'h24, 8'h04, 1'b1, 3'd5};
    tv[3] = '{3'd7, 8'hFF, 8'hFF, 1'b0, 3'd0};
    tv[4] = '{3'd3, 8'h11, 8'h00, 1'b1, 3'd4};
    tv[5] = '{3'd3, 8'h0F, 8'h00, 1'b1, 3'd0};
    tv[6] = '{3'd0, 8'h81, 8'h00, 1'b1, 3'd7};
    tv[7] = '{3'd5, 8'h41, 8'h40, 1'b1, 3'd0};
    tv[8] = '{3'd6, 8'hC0, 8'h00, 1'b1, 3'd7};
    tv[9] = '{3'd2, 8'h00, 8'h00, 1'b0, 3'd0};

    do_reset;
    chk("rst int_o",   {31'd0, bus.int_o},   32'd0);
    chk("rst irr_clr", {24'd0, bus.irr_clr}, 32'd0);
    chk("rst isr",     {24'd0, bus.isr},     32'd0);
    chk("rst data_o",  {24'd0, bus.data_o},  32'd0);
    chk("rst data_oe", {31'd0, bus.data_oe}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_reset;
      bus.eoi_lvl  = tv[i].lp;
      bus.set_prio = 1'b1;
      tick;
      bus.set_prio = 1'b0;
      bus.eoi_lvl  = 3'd0;
      bus.irr = tv[i].irr;
      bus.imr = tv[i].imr;
      tick;
      chk($sformatf("v%0d int_o", i), {31'd0, bus.int_o}, {31'd0, tv[i].exp_int});
      if (tv[i].exp_int) begin
        do_ack(clr, vec, oe);
        chk($sformatf("v%0d isr", i),     {24'd0, bus.isr}, 32'd1 << tv[i].exp_lvl);
        chk($sformatf("v%0d irr_clr", i), {24'd0, clr},     32'd1 << tv[i].exp_lvl);
        chk($sformatf("v%0d data_o", i),  {24'd0, vec},     {24'd0, VB, tv[i].exp_lvl});
        chk($sformatf("v%0d oe_seen", i), {31'd0, oe},      32'd1);
        chk($sformatf("v%0d oe_end", i),  {31'd0, bus.data_oe}, 32'd0);
        chk($sformatf("v%0d int_end", i), {31'd0, bus.int_o},   32'd0);
      end
    end

    // nesting: IR5 blocked by IR2 in service, IR1 preempts
    do_reset;
    bus.irr = 8'h24;
    tick;
    do_ack(clr, vec, oe);
    chk("nest isr0", {24'd0, bus.isr}, 32'h04);
    tick;
    chk("nest ir5 int_o", {31'd0, bus.int_o}, 32'd0);
    bus.irr = bus.irr | 8'h02;
    tick;
    chk("nest ir1 int_o", {31'd0, bus.int_o}, 32'd1);
    do_ack(clr, vec, oe);
    chk("nest isr1", {24'd0, bus.isr}, 32'h06);
    chk("nest vec",  {24'd0, vec},     {24'd0, VB, 3'd1});

    // rotating non-specific EOI: lp becomes 3 so IR4 outranks IR0
    do_reset;
    bus.irr = 8'h08;
    tick;
    do_ack(clr, vec, oe);
    chk("rot isr0", {24'd0, bus.isr}, 32'h08);
    bus.eoi_wr = 1'b1; bus.eoi_spec = 1'b0; bus.eoi_rot = 1'b1;
    tick;
    bus.eoi_wr = 1'b0; bus.eoi_rot = 1'b0;
    chk("rot isr1", {24'd0, bus.isr}, 32'h00);
    bus.irr = 8'h11;
    tick;
    chk("rot int_o", {31'd0, bus.int_o}, 32'd1);
    do_ack(clr, vec, oe);
    chk("rot vec", {24'd0, vec},     {24'd0, VB, 3'd4});
    chk("rot isr2", {24'd0, bus.isr}, 32'h10);

    // request withdrawn before the first pulse -> spurious acknowledge
    do_reset;
    bus.irr = 8'h04;
    tick;
    chk("spur int_o1", {31'd0, bus.int_o}, 32'd1);
    bus.irr = 8'h00;
    tick;
    chk("spur int_o0", {31'd0, bus.int_o}, 32'd0);
    do_ack(clr, vec, oe);
    chk("spur irr_clr", {24'd0, clr},     32'h00);
    chk("spur isr",     {24'd0, bus.isr}, 32'h00);
    chk("spur vec",     {24'd0, vec},     {24'd0, VB, 3'd7});

    // specific EOI on IR2 in the same cycle as ACK1 entry for IR2
    do_reset;
    bus.irr = 8'h04;
    tick;
    do_ack(clr, vec, oe);
    bus.irr = 8'h04;
    tick;
    chk("coll int_o", {31'd0, bus.int_o}, 32'd0);
    bus.inta_n = 1'b0;
    repeat (2) tick;
    bus.eoi_wr = 1'b1; bus.eoi_spec = 1'b1; bus.eoi_lvl = 3'd2;
    tick;
    bus.eoi_wr = 1'b0; bus.eoi_spec = 1'b0; bus.eoi_lvl = 3'd0;
    chk("coll isr",     {24'd0, bus.isr},     32'h04);
    chk("coll irr_clr", {24'd0, bus.irr_clr}, 32'h04);
    bus.irr = 8'h00;
    tick;
    bus.inta_n = 1'b1;
    repeat (3) tick;
    bus.inta_n = 1'b0;
    repeat (4) tick;
    chk("coll vec", {24'd0, bus.data_o}, {24'd0, VB, 3'd2});
    bus.inta_n = 1'b1;
    repeat (4) tick;

    // asynchronous reset while the vector is on the bus
    do_reset;
    bus.irr = 8'h04;
    tick;
    bus.inta_n = 1'b0;
    repeat (4) begin
      tick;
      if (bus.irr_clr != 8'h00) bus.irr = bus.irr & ~bus.irr_clr;
    end
    bus.inta_n = 1'b1;
    repeat (3) tick;
    bus.inta_n = 1'b0;
    repeat (4) tick;
    chk("rack2 data_oe", {31'd0, bus.data_oe}, 32'd1);
    chk("rack2 isr",     {24'd0, bus.isr},     32'h04);
    #2 rst = 1'b1;
    #1;
    chk("rack2 rst data_oe", {31'd0, bus.data_oe}, 32'd0);
    chk("rack2 rst isr",     {24'd0, bus.isr},     32'h00);
    chk("rack2 rst int_o",   {31'd0, bus.int_o},   32'd0);
    #1 rst = 1'b0;
    bus.inta_n = 1'b1;
    repeat (4) tick;
    chk("rack2 after data_oe", {31'd0, bus.data_oe}, 32'd0);
    chk("rack2 after isr",     {24'd0, bus.isr},     32'h00);

`ifdef PIC_AEOI_EN
    // auto-EOI: IR6 acknowledged, ISR self-clears at the end of ACK2
    do_reset;
    bus.aeoi = 1'b1;
    bus.irr  = 8'h40;
    tick;
    do_ack(clr, vec, oe);
    chk("aeoi vec", {24'd0, vec},     {24'd0, VB, 3'd6});
    chk("aeoi clr", {24'd0, clr},     32'h40);
    chk("aeoi isr", {24'd0, bus.isr}, 32'h00);
    bus.aeoi = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
